// File: rtl/vga_box_scroller_if.sv
// vga_box_scroller_if: pixel/sync/status bundle between the box scroller and the DAC and score logic
//   i_enable     : 1 = boxes advance once per frame, 0 = frozen
//   o_r/o_g/o_b  : 3/3/2 colour to the RGB DAC
//   o_hs/o_vs    : active-low syncs
//   o_frame_tick : one-clk pulse at the start of vertical blanking
//   o_passed     : respawn count, saturating at 9999
interface vga_box_scroller_if;
    logic        i_enable;
    logic [2:0]  o_r;
    logic [2:0]  o_g;
    logic [1:0]  o_b;
    logic        o_hs;
    logic        o_vs;
    logic        o_frame_tick;
    logic [13:0] o_passed;
    modport master (input i_enable, output o_r, o_g, o_b, o_hs, o_vs, o_frame_tick, o_passed);
    modport slave (output i_enable, input o_r, o_g, o_b, o_hs, o_vs, o_frame_tick, o_passed);
endinterface

// File: rtl/vga_box_scroller.sv
// vga_box_scroller: VGA raster plus NUM_BOXES boxes scrolling right-to-left, respawning at pseudo-random heights
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : master side of vga_box_scroller_if (enable in; RGB, syncs, frame_tick, passed out)
module vga_box_scroller #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          PIX_DIV   = 2,
    parameter int          NUM_BOXES = 4,
    parameter int          BOX_W     = 32,
    parameter int          BOX_H     = 64,
    parameter int          SPACING   = 192,
    parameter int          SPEED     = 2,
    parameter logic [7:0]  BOX_COLOR = 8'hE0,
    parameter logic [7:0]  BG_COLOR  = 8'h03
) (
    input logic               clk,
    input logic               rst_n,
    vga_box_scroller_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int Y_RANGE = V_ACTIVE - BOX_H + 1;
    localparam int Y_STEP  = (V_ACTIVE - BOX_H) / NUM_BOXES;
    localparam int WRAP    = NUM_BOXES * SPACING;

    logic [DW-1:0] r_div;
    logic [11:0]   r_h_cnt;
    logic [11:0]   r_v_cnt;
    logic          r_hs;
    logic          r_vs;
    logic [7:0]    r_rgb;
    logic          r_tick;
    logic [13:0]   r_passed;
    logic [15:0]   r_lfsr;
    logic [11:0]   r_pos  [NUM_BOXES];
    logic [11:0]   r_ytop [NUM_BOXES];

    logic          w_pix_en;
    logic          w_h_end;
    logic          w_v_end;
    logic          w_active;
    logic          w_hit;
    logic [3:0]    w_resp_cnt;
    logic [14:0]   w_sum;
    logic [13:0]   w_passed_nx;
    logic [11:0]   w_ymod;
    logic          w_fb;

    assign w_pix_en    = r_div == DW'(PIX_DIV - 1);
    assign w_h_end     = r_h_cnt == 12'(H_TOTAL - 1);
    assign w_v_end     = r_v_cnt == 12'(V_TOTAL - 1);
    assign w_active    = (r_h_cnt < 12'(H_ACTIVE)) && (r_v_cnt < 12'(V_ACTIVE));
    assign w_sum       = {1'b0, r_passed} + {11'b0, w_resp_cnt};
    assign w_passed_nx = (w_sum > 15'd9999) ? 14'd9999 : w_sum[13:0];
    assign w_ymod      = 12'({1'b0, r_lfsr[9:0]} % 11'(Y_RANGE));
    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // pos is right edge + 1, so a box is hit for pos-BOX_W <= h < pos without ever going negative
    always_comb begin
        w_hit      = 1'b0;
        w_resp_cnt = '0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            w_hit = w_hit | ((r_h_cnt < r_pos[i]) &&
                             (({1'b0, r_h_cnt} + 13'(BOX_W)) >= {1'b0, r_pos[i]}) &&
                             (r_v_cnt >= r_ytop[i]) &&
                             ({1'b0, r_v_cnt} < ({1'b0, r_ytop[i]} + 13'(BOX_H))));
            w_resp_cnt = w_resp_cnt + {3'b0, r_pos[i] <= 12'(SPEED)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_rgb    <= '0;
            r_tick   <= 1'b0;
            r_passed <= '0;
            r_lfsr   <= 16'hACE1;
            for (int i = 0; i < NUM_BOXES; i++) begin
                r_pos[i]  <= 12'(H_ACTIVE + BOX_W + i * SPACING);
                r_ytop[i] <= 12'(i * Y_STEP);
            end
        end else begin
            r_div <= w_pix_en ? '0 : r_div + DW'(1);
            if (w_pix_en) begin
                r_h_cnt <= w_h_end ? '0 : r_h_cnt + 12'd1;
                if (w_h_end)
                    r_v_cnt <= w_v_end ? '0 : r_v_cnt + 12'd1;
            end
            r_hs   <= !((r_h_cnt >= 12'(H_ACTIVE + H_FP)) && (r_h_cnt < 12'(H_ACTIVE + H_FP + H_SYNC)));
            r_vs   <= !((r_v_cnt >= 12'(V_ACTIVE + V_FP)) && (r_v_cnt < 12'(V_ACTIVE + V_FP + V_SYNC)));
            r_rgb  <= !w_active ? 8'h00 : w_hit ? BOX_COLOR : BG_COLOR;
            // Registered so the pulse covers the first clk of pixel (0, V_ACTIVE)
            r_tick <= w_pix_en && w_h_end && (r_v_cnt == 12'(V_ACTIVE - 1));
            if (r_tick && bus.i_enable) begin
                r_lfsr   <= {r_lfsr[14:0], w_fb};
                r_passed <= w_passed_nx;
                for (int i = 0; i < NUM_BOXES; i++) begin
                    if (r_pos[i] > 12'(SPEED)) begin
                        r_pos[i] <= r_pos[i] - 12'(SPEED);
                    end else begin
                        r_pos[i]  <= r_pos[i] + 12'(WRAP - SPEED);
                        r_ytop[i] <= w_ymod;
                    end
                end
            end
        end
    end

    assign bus.o_r          = r_rgb[7:5];
    assign bus.o_g          = r_rgb[4:2];
    assign bus.o_b          = r_rgb[1:0];
    assign bus.o_hs         = r_hs;
    assign bus.o_vs         = r_vs;
    assign bus.o_frame_tick = r_tick;
    assign bus.o_passed     = r_passed;
endmodule

// File: tb/tb_vga_box_scroller.sv
// tb_vga_box_scroller: directed checks of raster timing, scrolling, freeze, respawn, blanking and async reset
//   Uses a shrunken raster (24x16 pixels total, 16x12 active, 2 boxes) so whole frames stay short.
module tb_vga_box_scroller;
    localparam int HA = 16, HF = 2, HSY = 4, HB = 2;
    localparam int VA = 12, VF = 1, VSY = 2, VB = 1;
    localparam int PD = 2, NB = 2, BW = 4, BH = 4, SP = 12, SPD = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT * PD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] exp_lfsr;
    logic [11:0] exp_y0;

    vga_box_scroller_if bus();

    vga_box_scroller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .PIX_DIV(PD), .NUM_BOXES(NB), .BOX_W(BW), .BOX_H(BH),
        .SPACING(SP), .SPEED(SPD), .BOX_COLOR(8'hE0), .BG_COLOR(8'h03)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    wire [7:0] rgb = {bus.o_r, bus.o_g, bus.o_b};

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns one clk after the frame update edge
    task automatic wait_tick();
        int k;
        for (k = 0; k < 2000 && bus.o_frame_tick !== 1'b1; k++) cyc();
        n_checks++;
        if (k == 2000) begin
            n_fail++;
            $display("FAIL wait_tick: no frame_tick within %0d clk", k);
        end
        cyc();
    endtask

    // Returns with rgb showing pixel (h,v)
    task automatic goto_px(input int h, input int v);
        int k;
        for (k = 0; k < 2000; k++) begin
            if (dut.r_h_cnt == 12'(h) && dut.r_v_cnt == 12'(v)) break;
            cyc();
        end
        n_checks++;
        if (k == 2000) begin
            n_fail++;
            $display("FAIL goto_px: pixel (%0d,%0d) not reached", h, v);
        end
        cyc();
    endtask

    task automatic test_reset();
        n_checks++; if (bus.o_hs !== 1'b1 || bus.o_vs !== 1'b1) begin n_fail++; $display("FAIL reset_sync: hs=%b vs=%b want 1 1", bus.o_hs, bus.o_vs); end
        n_checks++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL reset_rgb: got %h want 00", rgb); end
        n_checks++; if (bus.o_frame_tick !== 1'b0 || bus.o_passed !== 14'd0) begin n_fail++; $display("FAIL reset_tick_passed: tick=%b passed=%0d want 0 0", bus.o_frame_tick, bus.o_passed); end
        n_checks++; if (dut.r_pos[0] !== 12'd20 || dut.r_pos[1] !== 12'd32) begin n_fail++; $display("FAIL reset_pos: got %0d %0d want 20 32", dut.r_pos[0], dut.r_pos[1]); end
        n_checks++; if (dut.r_ytop[0] !== 12'd0 || dut.r_ytop[1] !== 12'd4) begin n_fail++; $display("FAIL reset_ytop: got %0d %0d want 0 4", dut.r_ytop[0], dut.r_ytop[1]); end
        n_checks++; if (dut.r_lfsr !== 16'hACE1) begin n_fail++; $display("FAIL reset_lfsr: got %h want ace1", dut.r_lfsr); end
        n_checks++; if (dut.r_h_cnt !== 12'd0 || dut.r_v_cnt !== 12'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d %0d want 0 0", dut.r_h_cnt, dut.r_v_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_timing();
        int t_hs[$];
        int t_vs[$];
        int t_tk[$];
        int hs_low = -1;
        int vs_low = -1;
        int tk_h = -1;
        int tk_v = -1;
        logic ph = 1'b1;
        logic pv = 1'b1;
        for (int c = 0; c < 2 * FRAME + 50; c++) begin
            cyc();
            if (ph && !bus.o_hs) t_hs.push_back(c);
            if (pv && !bus.o_vs) t_vs.push_back(c);
            if (!ph && bus.o_hs && t_hs.size() > 0 && hs_low < 0) hs_low = c - t_hs[0];
            if (!pv && bus.o_vs && t_vs.size() > 0 && vs_low < 0) vs_low = c - t_vs[0];
            if (bus.o_frame_tick) begin
                if (t_tk.size() == 0) begin
                    tk_h = int'(dut.r_h_cnt);
                    tk_v = int'(dut.r_v_cnt);
                end
                t_tk.push_back(c);
            end
            ph = bus.o_hs;
            pv = bus.o_vs;
        end
        n_checks++; if (hs_low != HSY * PD) begin n_fail++; $display("FAIL hs_low: got %0d clk want %0d", hs_low, HSY * PD); end
        n_checks++; if (t_hs.size() < 2 || t_hs[1] - t_hs[0] != HT * PD) begin n_fail++; $display("FAIL hs_period: got %0d falls want period %0d", t_hs.size(), HT * PD); end
        n_checks++; if (vs_low != VSY * HT * PD) begin n_fail++; $display("FAIL vs_low: got %0d clk want %0d", vs_low, VSY * HT * PD); end
        n_checks++; if (t_vs.size() != 2 || t_vs[1] - t_vs[0] != FRAME) begin n_fail++; $display("FAIL vs_period: got %0d falls want 2 with period %0d", t_vs.size(), FRAME); end
        n_checks++; if (t_tk.size() != 2 || t_tk[1] - t_tk[0] != FRAME) begin n_fail++; $display("FAIL tick_count: got %0d ticks want 2 spaced %0d", t_tk.size(), FRAME); end
        n_checks++; if (tk_h != 0 || tk_v != VA) begin n_fail++; $display("FAIL tick_pixel: got (%0d,%0d) want (0,%0d)", tk_h, tk_v, VA); end
        n_checks++; if (dut.r_pos[0] !== 12'd20) begin n_fail++; $display("FAIL timing_frozen_pos: got %0d want 20", dut.r_pos[0]); end
    endtask

    task automatic test_scroll();
        bus.i_enable = 1'b1;
        wait_tick();
        bus.i_enable = 1'b0;
        exp_lfsr = lfsr_step(16'hACE1);
        n_checks++; if (dut.r_pos[0] !== 12'd18 || dut.r_pos[1] !== 12'd30) begin n_fail++; $display("FAIL scroll_pos: got %0d %0d want 18 30", dut.r_pos[0], dut.r_pos[1]); end
        n_checks++; if (dut.r_lfsr !== exp_lfsr) begin n_fail++; $display("FAIL scroll_lfsr: got %h want %h", dut.r_lfsr, exp_lfsr); end
        goto_px(13, 0);
        n_checks++; if (rgb !== 8'h03) begin n_fail++; $display("FAIL scroll_px13: got %h want 03", rgb); end
        goto_px(14, 0);
        n_checks++; if (rgb !== 8'hE0) begin n_fail++; $display("FAIL scroll_px14: got %h want e0", rgb); end
        goto_px(15, 3);
        n_checks++; if (rgb !== 8'hE0) begin n_fail++; $display("FAIL scroll_px15_3: got %h want e0", rgb); end
        goto_px(14, 4);
        n_checks++; if (rgb !== 8'h03) begin n_fail++; $display("FAIL scroll_px14_4: got %h want 03", rgb); end
    endtask

    task automatic test_freeze();
        for (int f = 0; f < 3; f++) begin
            goto_px(10, 1);
            n_checks++; if (rgb !== 8'h03) begin n_fail++; $display("FAIL freeze_bg frame %0d: got %h want 03", f, rgb); end
            goto_px(14, 1);
            n_checks++; if (rgb !== 8'hE0) begin n_fail++; $display("FAIL freeze_box frame %0d: got %h want e0", f, rgb); end
            wait_tick();
        end
        n_checks++; if (dut.r_pos[0] !== 12'd18 || dut.r_pos[1] !== 12'd30) begin n_fail++; $display("FAIL freeze_pos: got %0d %0d want 18 30", dut.r_pos[0], dut.r_pos[1]); end
        n_checks++; if (dut.r_ytop[0] !== 12'd0 || dut.r_ytop[1] !== 12'd4) begin n_fail++; $display("FAIL freeze_ytop: got %0d %0d want 0 4", dut.r_ytop[0], dut.r_ytop[1]); end
        n_checks++; if (dut.r_lfsr !== exp_lfsr || bus.o_passed !== 14'd0) begin n_fail++; $display("FAIL freeze_lfsr_passed: got %h %0d want %h 0", dut.r_lfsr, bus.o_passed, exp_lfsr); end
    endtask

    task automatic test_respawn();
        logic [15:0] l = 16'hACE1;
        for (int k = 0; k < 9; k++) l = lfsr_step(l);
        exp_y0 = 12'(int'(l[9:0]) % (VA - BH + 1));
        exp_lfsr = lfsr_step(l);
        bus.i_enable = 1'b1;
        repeat (8) wait_tick();
        n_checks++; if (dut.r_pos[0] !== 12'd2 || bus.o_passed !== 14'd0) begin n_fail++; $display("FAIL pre_respawn: pos0=%0d passed=%0d want 2 0", dut.r_pos[0], bus.o_passed); end
        wait_tick();
        bus.i_enable = 1'b0;
        n_checks++; if (dut.r_pos[0] !== 12'd24) begin n_fail++; $display("FAIL respawn_pos0: got %0d want 24", dut.r_pos[0]); end
        n_checks++; if (bus.o_passed !== 14'd1) begin n_fail++; $display("FAIL respawn_passed: got %0d want 1", bus.o_passed); end
        n_checks++; if (dut.r_ytop[0] !== exp_y0 || exp_y0 >= 12'(VA - BH + 1)) begin n_fail++; $display("FAIL respawn_ytop0: got %0d want %0d", dut.r_ytop[0], exp_y0); end
        n_checks++; if (dut.r_pos[1] !== 12'd12 || dut.r_ytop[1] !== 12'd4) begin n_fail++; $display("FAIL respawn_box1: got %0d %0d want 12 4", dut.r_pos[1], dut.r_ytop[1]); end
        n_checks++; if (dut.r_lfsr !== exp_lfsr) begin n_fail++; $display("FAIL respawn_lfsr: got %h want %h", dut.r_lfsr, exp_lfsr); end
    endtask

    // Frozen state now: box0 pos 24 (off-screen), box1 pos 12 at rows 4..7 -> box pixels h 8..11
    task automatic test_blank();
        int ph;
        int pv;
        int blank_err = 0;
        int act_err = 0;
        logic [7:0] want;
        logic [7:0] bad_got = 8'h00;
        logic [7:0] bad_want = 8'h00;
        cyc();
        ph = int'(dut.r_h_cnt);
        pv = int'(dut.r_v_cnt);
        for (int c = 0; c < FRAME + 4; c++) begin
            cyc();
            if (ph >= HA || pv >= VA) begin
                if (rgb !== 8'h00) blank_err++;
            end else begin
                want = (ph < 12 && ph + BW >= 12 && pv >= 4 && pv < 4 + BH) ? 8'hE0 : 8'h03;
                if (rgb !== want) begin
                    act_err++;
                    bad_got = rgb;
                    bad_want = want;
                end
            end
            ph = int'(dut.r_h_cnt);
            pv = int'(dut.r_v_cnt);
        end
        n_checks++; if (blank_err != 0) begin n_fail++; $display("FAIL blanking: got %0d non-black blank samples want 0", blank_err); end
        n_checks++; if (act_err != 0) begin n_fail++; $display("FAIL active_pixels: got %0d wrong samples (last %h want %h) want 0", act_err, bad_got, bad_want); end
    endtask

    task automatic test_reset_mid();
        int k;
        int e;
        for (k = 0; k < 2000; k++) begin
            if (dut.r_h_cnt == 12'd10 && dut.r_v_cnt == 12'd6) break;
            cyc();
        end
        n_checks++; if (k == 2000 || rgb !== 8'hE0) begin n_fail++; $display("FAIL mid_pre: got rgb %h after %0d clk want e0", rgb, k); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_hs !== 1'b1 || bus.o_vs !== 1'b1 || rgb !== 8'h00) begin n_fail++; $display("FAIL mid_reset_out: hs=%b vs=%b rgb=%h want 1 1 00", bus.o_hs, bus.o_vs, rgb); end
        n_checks++; if (bus.o_passed !== 14'd0 || dut.r_pos[0] !== 12'd20) begin n_fail++; $display("FAIL mid_reset_state: passed=%0d pos0=%0d want 0 20", bus.o_passed, dut.r_pos[0]); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (e = 1; e <= 100; e++) begin
            cyc();
            if (bus.o_hs === 1'b0) break;
        end
        n_checks++; if (e != 2 * (HA + HF) + 1 || dut.r_h_cnt !== 12'(HA + HF) || dut.r_v_cnt !== 12'd0) begin n_fail++; $display("FAIL mid_first_hs: got edge %0d at (%0d,%0d) want edge %0d at (%0d,0)", e, dut.r_h_cnt, dut.r_v_cnt, 2 * (HA + HF) + 1, HA + HF); end
        bus.i_enable = 1'b1;
        wait_tick();
        bus.i_enable = 1'b0;
        n_checks++; if (dut.r_pos[0] !== 12'd18 || dut.r_lfsr !== lfsr_step(16'hACE1) || bus.o_passed !== 14'd0) begin n_fail++; $display("FAIL mid_replay_state: pos0=%0d lfsr=%h passed=%0d want 18 %h 0", dut.r_pos[0], dut.r_lfsr, bus.o_passed, lfsr_step(16'hACE1)); end
        goto_px(13, 0);
        n_checks++; if (rgb !== 8'h03) begin n_fail++; $display("FAIL mid_replay_px13: got %h want 03", rgb); end
        goto_px(14, 0);
        n_checks++; if (rgb !== 8'hE0) begin n_fail++; $display("FAIL mid_replay_px14: got %h want e0", rgb); end
    endtask

    initial begin
        bus.i_enable = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_timing();
        test_scroll();
        test_freeze();
        test_respawn();
        test_blank();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
